// File: rtl/vga_upd_pkg.sv
// Shared types and register-bank addresses for the VGA display update sequencer.
package vga_upd_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } seqState_t;

    localparam logic [ADDR_W-1:0] SEG_RELOJ = 4'd1;
    localparam logic [ADDR_W-1:0] MIN_RELOJ = 4'd2;
    localparam logic [ADDR_W-1:0] HOR_RELOJ = 4'd3;
    localparam logic [ADDR_W-1:0] YEAR      = 4'd4;
    localparam logic [ADDR_W-1:0] MON       = 4'd5;
    localparam logic [ADDR_W-1:0] DAY       = 4'd6;
    localparam logic [ADDR_W-1:0] SEG_CRONO = 4'd7;
    localparam logic [ADDR_W-1:0] MIN_CRONO = 4'd8;
    localparam logic [ADDR_W-1:0] HOR_CRONO = 4'd9;
    localparam logic [ADDR_W-1:0] CURSOR    = 4'd10;
    localparam logic [ADDR_W-1:0] RING      = 4'd11;
    localparam logic [ADDR_W-1:0] ACT       = 4'd12;

endpackage

// File: rtl/vga_upd_edge_timer.sv
// VSync falling-edge detector and saturating read-timeout counter.
module vga_upd_edge_timer
    import vga_upd_pkg::*;
#(
    parameter int unsigned RD_TIMEOUT = 15
) (
    input  logic CLK,
    input  logic RESET,
    input  logic VSync,
    input  logic cntInc,
    input  logic cntClr,
    output logic fallEdge_c,
    output logic timeoutHit_c
);

    logic             vsQ;
    logic             armed;
    logic [CNT_W-1:0] cnt;

    // armed masks the first cycle out of reset so a VSync already low does not start a sweep
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vsQ   <= 1'b1;
            armed <= 1'b0;
            cnt   <= '0;
        end else begin
            vsQ   <= VSync;
            armed <= 1'b1;
            if (cntClr) begin
                cnt <= '0;
            end else if (cntInc && (cnt < CNT_W'(RD_TIMEOUT))) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign fallEdge_c   = armed & vsQ & ~VSync;
    // Hit on the cycle whose increment brings the count to RD_TIMEOUT
    assign timeoutHit_c = (cnt >= CNT_W'(RD_TIMEOUT - 1));

endmodule

// File: rtl/vga_display_update_seq.sv
// Per-frame refresh sequencer: reads FIRST_ADDR..LAST_ADDR from the source and writes them to the renderer.
module vga_display_update_seq
    import vga_upd_pkg::*;
#(
    parameter int unsigned FIRST_ADDR = 1,
    parameter int unsigned LAST_ADDR  = 12,
    parameter int unsigned RD_TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              VSync,
    output logic              SrcReq,
    output logic [ADDR_W-1:0] SrcAddr,
    input  logic              SrcAck,
    input  logic [DATA_W-1:0] SrcData,
    output logic [ADDR_W-1:0] MemAddrOut,
    output logic [DATA_W-1:0] MemDataOut,
    output logic              Write,
    output logic              Busy,
    output logic              FrameDone,
    output logic              TimeoutErr,
    output logic              AbortErr
);

    seqState_t         state, stateNxt;
    logic              srcReqNxt, writeNxt, frameDoneNxt, timeoutErrNxt, abortErrNxt;
    logic [ADDR_W-1:0] srcAddrNxt, memAddrNxt;
    logic [DATA_W-1:0] memDataNxt;
    logic              cntInc, cntClr, fallEdge_c, timeoutHit_c;

    vga_upd_edge_timer #(
        .RD_TIMEOUT (RD_TIMEOUT)
    ) uEdgeTimer (
        .CLK          (CLK),
        .RESET        (RESET),
        .VSync        (VSync),
        .cntInc       (cntInc),
        .cntClr       (cntClr),
        .fallEdge_c   (fallEdge_c),
        .timeoutHit_c (timeoutHit_c)
    );

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            SrcReq     <= 1'b0;
            SrcAddr    <= ADDR_W'(FIRST_ADDR);
            MemAddrOut <= '0;
            MemDataOut <= '0;
            Write      <= 1'b0;
            Busy       <= 1'b0;
            FrameDone  <= 1'b0;
            TimeoutErr <= 1'b0;
            AbortErr   <= 1'b0;
        end else begin
            state      <= stateNxt;
            SrcReq     <= srcReqNxt;
            SrcAddr    <= srcAddrNxt;
            MemAddrOut <= memAddrNxt;
            MemDataOut <= memDataNxt;
            Write      <= writeNxt;
            Busy       <= (stateNxt != IDLE);
            FrameDone  <= frameDoneNxt;
            TimeoutErr <= timeoutErrNxt;
            AbortErr   <= abortErrNxt;
        end
    end

    // Next state and output values; VSync high in REQ/WRITE aborts ahead of ack or timeout
    always_comb begin
        stateNxt      = state;
        srcReqNxt     = SrcReq;
        srcAddrNxt    = SrcAddr;
        memAddrNxt    = MemAddrOut;
        memDataNxt    = MemDataOut;
        writeNxt      = 1'b0;
        frameDoneNxt  = 1'b0;
        timeoutErrNxt = 1'b0;
        abortErrNxt   = 1'b0;
        cntInc        = 1'b0;
        cntClr        = 1'b0;

        case (state)
            IDLE: begin
                cntClr = 1'b1;
                if (fallEdge_c) begin
                    srcAddrNxt = ADDR_W'(FIRST_ADDR);
                    srcReqNxt  = 1'b1;
                    stateNxt   = REQ;
                end
            end
            REQ: begin
                if (VSync) begin
                    srcReqNxt   = 1'b0;
                    abortErrNxt = 1'b1;
                    stateNxt    = IDLE;
                end else if (SrcAck) begin
                    memDataNxt = SrcData;
                    memAddrNxt = SrcAddr;
                    srcReqNxt  = 1'b0;
                    writeNxt   = 1'b1;
                    stateNxt   = WRITE;
                end else begin
                    cntInc = 1'b1;
                    if (timeoutHit_c) begin
                        srcReqNxt     = 1'b0;
                        timeoutErrNxt = 1'b1;
                        stateNxt      = WRITE;
                    end
                end
            end
            WRITE: begin
                if (VSync) begin
                    srcReqNxt   = 1'b0;
                    abortErrNxt = 1'b1;
                    stateNxt    = IDLE;
                end else begin
                    cntClr = 1'b1;
                    if (SrcAddr == ADDR_W'(LAST_ADDR)) begin
                        stateNxt = DONE;
                    end else begin
                        srcAddrNxt = SrcAddr + ADDR_W'(1);
                        srcReqNxt  = 1'b1;
                        stateNxt   = REQ;
                    end
                end
            end
            DONE: begin
                frameDoneNxt = 1'b1;
                srcAddrNxt   = ADDR_W'(FIRST_ADDR);
                stateNxt     = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vga_display_update_seq.sv
// Directed bench for the VGA display update sequencer with a behavioural source and write monitor.
module tb_vga_display_update_seq;
    import vga_upd_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       VSync = 1'b0;
    logic       SrcReq;
    logic [3:0] SrcAddr;
    logic       SrcAck = 1'b0;
    logic [7:0] SrcData = 8'h00;
    logic [3:0] MemAddrOut;
    logic [7:0] MemDataOut;
    logic       Write, Busy, FrameDone, TimeoutErr, AbortErr;

    int checks = 0;
    int failures = 0;

    // Source behaviour knobs (written by the stimulus, read by the source model)
    int noAckAddr = 0;
    int delayAddr = 0;
    int delayCyc  = 0;
    int waitCnt   = 0;

    // Monitor state
    int         cyc = 0;
    int         fdCnt = 0;
    int         toCnt = 0;
    int         abCnt = 0;
    int         fdCyc = 0;
    int         reqRiseCyc = 0;
    int         reqCycles [16] = '{default: 0};
    logic       prevReq = 1'b0;
    logic [11:0] wrLog [$];

    vga_display_update_seq #(
        .FIRST_ADDR (1),
        .LAST_ADDR  (12),
        .RD_TIMEOUT (15)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .VSync      (VSync),
        .SrcReq     (SrcReq),
        .SrcAddr    (SrcAddr),
        .SrcAck     (SrcAck),
        .SrcData    (SrcData),
        .MemAddrOut (MemAddrOut),
        .MemDataOut (MemDataOut),
        .Write      (Write),
        .Busy       (Busy),
        .FrameDone  (FrameDone),
        .TimeoutErr (TimeoutErr),
        .AbortErr   (AbortErr)
    );

    always #5 CLK = ~CLK;

    // Source: answers each request after the configured wait with data = addr*16
    always @(negedge CLK) begin
        if (SrcReq) begin
            SrcAck  = (int'(SrcAddr) != noAckAddr) &&
                      (waitCnt >= ((int'(SrcAddr) == delayAddr) ? delayCyc : 0));
            SrcData = {SrcAddr, 4'h0};
            waitCnt = waitCnt + 1;
        end else begin
            SrcAck  = 1'b0;
            waitCnt = 0;
        end
    end

    // Monitor: logs renderer writes and counts pulses
    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (RESET === 1'b0) begin
            if (Write) wrLog.push_back({MemAddrOut, MemDataOut});
            if (FrameDone) begin
                fdCnt <= fdCnt + 1;
                fdCyc <= cyc;
            end
            if (TimeoutErr) toCnt <= toCnt + 1;
            if (AbortErr) abCnt <= abCnt + 1;
            if (SrcReq) reqCycles[SrcAddr] <= reqCycles[SrcAddr] + 1;
            if (SrcReq && !prevReq && SrcAddr == SEG_RELOJ) reqRiseCyc <= cyc;
        end
        prevReq <= SrcReq;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic doSweep();
        VSync = 1'b1;
        repeat (2) @(negedge CLK);
        VSync = 1'b0;
    endtask

    task automatic waitFrame(input int fdBase);
        int n = 0;
        while (fdCnt == fdBase && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check("frame_wait", 32'(fdCnt > fdBase), 1);
        repeat (3) @(negedge CLK);
    endtask

    task automatic checkSweep(input string tag, input int base, input int skipAddr);
        int k = 0;
        int expN = (skipAddr != 0) ? 11 : 12;
        check({tag, "_count"}, 32'(wrLog.size() - base), 32'(expN));
        for (int a = 1; a <= 12; a++) begin
            if (a == skipAddr) continue;
            if (base + k < wrLog.size())
                check({tag, "_wr"}, 32'(wrLog[base + k]), 32'({4'(a), 8'(a * 16)}));
            k++;
        end
    endtask

    initial begin
        int base, fdB, toB, abB, reqB, n;

        // Reset with VSync already low: no start afterwards
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);
        check("rst_srcreq", 32'(SrcReq), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_write", 32'(Write), 0);
        check("rst_srcaddr", 32'(SrcAddr), 1);
        check("rst_memaddr", 32'(MemAddrOut), 0);
        check("rst_memdata", 32'(MemDataOut), 0);

        // Zero-wait sweep
        base = wrLog.size(); fdB = fdCnt;
        doSweep();
        waitFrame(fdB);
        checkSweep("sweep0", base, 0);
        check("sweep0_latency", 32'(fdCyc - reqRiseCyc), 25);
        check("sweep0_fd", 32'(fdCnt - fdB), 1);
        check("sweep0_idle", 32'(Busy), 0);

        // Ack delayed 3 cycles on address 5
        delayAddr = int'(MON); delayCyc = 3;
        base = wrLog.size(); fdB = fdCnt; reqB = reqCycles[5];
        doSweep();
        waitFrame(fdB);
        checkSweep("delay", base, 0);
        check("delay_req_hold", 32'(reqCycles[5] - reqB), 4);
        check("delay_latency", 32'(fdCyc - reqRiseCyc), 28);
        delayAddr = 0; delayCyc = 0;

        // Address 7 never acked: timeout skip
        noAckAddr = int'(SEG_CRONO);
        base = wrLog.size(); fdB = fdCnt; toB = toCnt; reqB = reqCycles[7];
        doSweep();
        waitFrame(fdB);
        checkSweep("timeout", base, 7);
        check("timeout_req_hold", 32'(reqCycles[7] - reqB), 15);
        check("timeout_pulses", 32'(toCnt - toB), 1);
        check("timeout_latency", 32'(fdCyc - reqRiseCyc), 39);
        noAckAddr = 0;

        // VSync rises the same cycle address 4 is acked
        base = wrLog.size(); fdB = fdCnt; abB = abCnt;
        doSweep();
        n = 0;
        while (!(SrcReq && SrcAddr == YEAR) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        VSync = 1'b1;
        @(posedge CLK); #1;
        check("abort_pulse", 32'(AbortErr), 1);
        check("abort_write", 32'(Write), 0);
        check("abort_srcreq", 32'(SrcReq), 0);
        check("abort_busy", 32'(Busy), 0);
        repeat (40) @(negedge CLK);
        check("abort_writes", 32'(wrLog.size() - base), 3);
        check("abort_no_fd", 32'(fdCnt - fdB), 0);
        check("abort_once", 32'(abCnt - abB), 1);

        // Sub-cycle VSync glitch mid-sweep is ignored
        base = wrLog.size(); fdB = fdCnt;
        doSweep();
        repeat (8) @(negedge CLK);
        #1 VSync = 1'b1;
        #2 VSync = 1'b0;
        waitFrame(fdB);
        checkSweep("glitch", base, 0);
        check("glitch_fd", 32'(fdCnt - fdB), 1);

        // Reset while writing address 9, then a fresh sweep
        doSweep();
        n = 0;
        while (!(Write && MemAddrOut == HOR_CRONO) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        RESET = 1'b1;
        @(posedge CLK); #1;
        check("rstw_write", 32'(Write), 0);
        check("rstw_srcreq", 32'(SrcReq), 0);
        check("rstw_busy", 32'(Busy), 0);
        check("rstw_srcaddr", 32'(SrcAddr), 1);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        base = wrLog.size(); fdB = fdCnt;
        doSweep();
        waitFrame(fdB);
        checkSweep("restart", base, 0);
        check("restart_latency", 32'(fdCyc - reqRiseCyc), 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
